// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet framer.
package uart_pkt_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} pkt_state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] data_byte);
    return acc + data_byte;
  endfunction

endpackage

// File: rtl/uart_pkt_tx.sv
// Packet framer: header, payload MSB first, optional two's-complement checksum,
// handed byte by byte to a UART transmitter paced by tx_rdy_i.
module uart_pkt_tx
  import uart_pkt_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 3,
  parameter logic [7:0]  HDR_BYTE      = HDR_DEFAULT,
  parameter bit          CHK_EN        = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pkt_vld_i,
  input  logic [8*PAYLOAD_BYTES-1:0] pkt_data_i,
  output logic                       pkt_rdy_o,
  input  logic                       tx_rdy_i,
  output logic                       tx_start_o,
  output logic [7:0]                 tx_data_o,
  output logic                       busy_o,
  output logic                       pkt_done_o
);

  localparam int unsigned Total = 1 + PAYLOAD_BYTES + (CHK_EN ? 1 : 0);
  localparam int unsigned IdxW  = $clog2(Total);
  localparam int unsigned PayW  = 8 * PAYLOAD_BYTES;

  localparam logic [IdxW-1:0] LastIdx    = IdxW'(Total - 1);
  localparam logic [IdxW-1:0] LastPayIdx = IdxW'(PAYLOAD_BYTES);

  pkt_state_t      state_q;
  logic [PayW-1:0] shadow_q;
  logic [IdxW-1:0] byte_idx_q;
  logic [7:0]      chk_q;
  logic [7:0]      tx_data_q;
  logic            busy_seen_q;

  logic            wait_exit;
  logic            last_byte;
  logic [7:0]      next_pay;

  // Exit WAIT only after the transmitter has visibly gone busy and come back.
  assign wait_exit  = (state_q == WAIT) && busy_seen_q && tx_rdy_i;
  assign last_byte  = (byte_idx_q == LastIdx);
  assign next_pay   = shadow_q[PayW-1 -: 8];

  assign pkt_rdy_o  = (state_q == IDLE);
  assign busy_o     = ~pkt_rdy_o;
  assign tx_start_o = (state_q == SEND) && tx_rdy_i;
  assign pkt_done_o = wait_exit && last_byte;
  assign tx_data_o  = tx_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      byte_idx_q  <= '0;
      chk_q       <= 8'h00;
      tx_data_q   <= 8'h00;
      busy_seen_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pkt_vld_i) begin
            shadow_q   <= pkt_data_i;
            byte_idx_q <= '0;
            chk_q      <= 8'h00;
            tx_data_q  <= HDR_BYTE;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_rdy_i) begin
            busy_seen_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (!tx_rdy_i) begin
            busy_seen_q <= 1'b1;
          end else if (busy_seen_q) begin
            if (last_byte) begin
              state_q <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              state_q    <= SEND;
              if (byte_idx_q < LastPayIdx) begin
                tx_data_q <= next_pay;
                chk_q     <= chk_add(chk_q, next_pay);
                shadow_q  <= shadow_q << 8;
              end else begin
                tx_data_q <= 8'h00 - chk_q;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Randomized bench for uart_pkt_tx against a queue-based packet model, with a
// transmitter emulator that randomizes byte duration and ready/start overlap.
module tb_uart_pkt_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_vld = 1'b0;
  logic [23:0] pkt_data = 24'h0;
  logic        pkt_rdy, tx_start, busy, pkt_done;
  logic [7:0]  tx_data;
  logic        tx_rdy;

  logic        nc_vld = 1'b0;
  logic [23:0] nc_pdata = 24'h123456;
  logic        nc_rdy, nc_start, nc_busy, nc_done;
  logic [7:0]  nc_data;
  logic        nc_txrdy = 1'b1;
  int unsigned nc_cnt = 0;

  logic        hold_busy = 1'b0;
  logic        tx_q = 1'b1;
  int unsigned ph = 0;
  int unsigned len = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int nc_done_cnt = 0;
  bit armed = 1'b0;

  logic [7:0] q[$];
  logic [7:0] log_q[$];
  logic [7:0] nc_log[$];
  bit         m_in = 1'b0;
  bit         m_gate = 1'b0;
  bit         m_low = 1'b0;
  logic [7:0] m_last = 8'h00;

  always #5 clk = ~clk;

  uart_pkt_tx #(.PAYLOAD_BYTES(3), .HDR_BYTE(8'hA5), .CHK_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .pkt_vld_i(pkt_vld), .pkt_data_i(pkt_data),
    .pkt_rdy_o(pkt_rdy), .tx_rdy_i(tx_rdy), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .busy_o(busy), .pkt_done_o(pkt_done)
  );

  uart_pkt_tx #(.PAYLOAD_BYTES(3), .HDR_BYTE(8'hA5), .CHK_EN(1'b0)) dut_nc (
    .clk_i(clk), .rst_i(rst), .pkt_vld_i(nc_vld), .pkt_data_i(nc_pdata),
    .pkt_rdy_o(nc_rdy), .tx_rdy_i(nc_txrdy), .tx_start_o(nc_start), .tx_data_o(nc_data),
    .busy_o(nc_busy), .pkt_done_o(nc_done)
  );

  // Transmitter emulator: ready may linger one cycle after a start, then busy 2..7 cycles.
  assign tx_rdy = tx_q && !hold_busy;
  always @(posedge clk) begin
    case (ph)
      0: if (tx_start && tx_rdy) begin
        len <= $urandom_range(1, 6);
        if ($urandom_range(0, 3) == 0) ph <= 1;
        else begin
          ph   <= 2;
          tx_q <= 1'b0;
        end
      end
      1: begin
        ph   <= 2;
        tx_q <= 1'b0;
      end
      default: if (len == 0) begin
        ph   <= 0;
        tx_q <= 1'b1;
      end else len <= len - 1;
    endcase
  end

  always @(posedge clk) begin
    if (nc_start && nc_txrdy) begin
      nc_txrdy <= 1'b0;
      nc_cnt   <= 3;
    end else if (!nc_txrdy) begin
      if (nc_cnt == 0) nc_txrdy <= 1'b1;
      else nc_cnt <= nc_cnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a packet is a byte queue; a byte may start while the gate is open,
  // the gate reopens once the transmitter has gone busy and returned to ready.
  initial begin
    logic exp_start, exp_done;
    int   sum;
    forever begin
      @(negedge clk);
      if (armed) begin
        exp_start = m_in && m_gate && (q.size() > 0) && tx_rdy;
        exp_done  = m_in && !m_gate && m_low && tx_rdy && (q.size() == 0);
        chk("pkt_rdy", pkt_rdy, !m_in);
        chk("busy", busy, m_in);
        chk("tx_start", tx_start, exp_start);
        chk("pkt_done", pkt_done, exp_done);
        if (m_in) chk("tx_data", tx_data, (m_gate && q.size() > 0) ? q[0] : m_last);
        if (tx_start) log_q.push_back(tx_data);
        if (pkt_done) n_done++;
        if (nc_start && nc_txrdy) nc_log.push_back(nc_data);
        if (nc_done) nc_done_cnt++;

        if (rst) begin
          q.delete();
          m_in = 1'b0;
          m_gate = 1'b0;
          m_low = 1'b0;
        end else if (!m_in) begin
          if (pkt_vld) begin
            sum = 0;
            q.push_back(8'hA5);
            for (int i = 2; i >= 0; i--) begin
              q.push_back(pkt_data[i*8 +: 8]);
              sum += int'(pkt_data[i*8 +: 8]);
            end
            q.push_back(8'((256 - (sum % 256)) % 256));
            m_in = 1'b1;
            m_gate = 1'b1;
          end
        end else if (m_gate) begin
          if (tx_rdy) begin
            m_last = q.pop_front();
            m_gate = 1'b0;
            m_low = 1'b0;
          end
        end else if (!tx_rdy) begin
          m_low = 1'b1;
        end else if (m_low) begin
          if (q.size() > 0) m_gate = 1'b1;
          else m_in = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [23:0] d);
    int cnt = 0;
    pkt_vld = 1'b1;
    pkt_data = d;
    @(negedge clk);
    while (!pkt_rdy && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 2000) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    pkt_vld = 1'b0;
    pkt_data = 24'($urandom);
  endtask

  task automatic wait_done();
    int cnt = 0;
    @(negedge clk);
    while (!pkt_done && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 2000) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pkt_rdy", pkt_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_pkt_done", pkt_done, 0);
    rst = 1'b0;

    // CHK_EN=0 instance runs one packet alongside the main tests.
    nc_vld = 1'b1;
    @(posedge clk);
    #1;
    nc_vld = 1'b0;

    log_q.delete();
    send(24'h123456);
    wait_done();
    chk("t1_len", log_q.size(), 5);
    chk("t1_b0", log_q[0], 8'hA5);
    chk("t1_b1", log_q[1], 8'h12);
    chk("t1_b2", log_q[2], 8'h34);
    chk("t1_b3", log_q[3], 8'h56);
    chk("t1_chk", log_q[4], 8'h64);

    log_q.delete();
    send(24'hFFFFFF);
    wait_done();
    chk("t2_chk_ff", log_q[4], 8'h03);
    log_q.delete();
    send(24'h000000);
    wait_done();
    chk("t2_chk_00", log_q[4], 8'h00);

    log_q.delete();
    hold_busy = 1'b1;
    send(24'h55AA01);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("t3_no_start", tx_start, 0);
    chk("t3_hdr_held", tx_data, 8'hA5);
    @(posedge clk);
    #1;
    hold_busy = 1'b0;
    @(negedge clk);
    chk("t3_first_pulse", tx_start, 1);
    wait_done();
    chk("t3_len", log_q.size(), 5);

    log_q.delete();
    send(24'h0F1E2D);
    repeat (2) @(posedge clk);
    #1;
    pkt_vld = 1'b1;
    pkt_data = 24'hDEADBE;
    repeat (3) @(posedge clk);
    #1;
    pkt_vld = 1'b0;
    wait_done();
    chk("t4_len", log_q.size(), 5);
    chk("t4_kept", log_q[1], 8'h0F);
    log_q.delete();
    send(24'hDEADBE);
    wait_done();
    chk("t4_second", log_q[1], 8'hDE);

    log_q.delete();
    send(24'h123456);
    cnt = 0;
    while (log_q.size() < 2 && cnt < 2000) begin
      @(posedge clk);
      cnt++;
    end
    if (cnt >= 2000) chk("t5_timeout", 0, 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_pkt_rdy", pkt_rdy, 1);
    chk("t5_tx_start", tx_start, 0);
    @(posedge clk);
    #1;
    log_q.delete();
    send(24'hABCDEF);
    wait_done();
    chk("t5_hdr", log_q[0], 8'hA5);
    chk("t5_b1", log_q[1], 8'hAB);
    chk("t5_chk", log_q[4], 8'h99);

    pkt_vld = 1'b1;
    pkt_data = 24'($urandom);
    for (int p = 0; p < 30; p++) begin
      cnt = 0;
      @(negedge clk);
      while (!pkt_rdy && cnt < 2000) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 2000) chk("t6_timeout", 0, 1);
      @(posedge clk);
      #1;
      pkt_data = 24'($urandom);
    end
    pkt_vld = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    #1;

    chk("done_total", n_done, 37);
    chk("nc_len", nc_log.size(), 4);
    chk("nc_b0", nc_log[0], 8'hA5);
    chk("nc_b1", nc_log[1], 8'h12);
    chk("nc_b2", nc_log[2], 8'h34);
    chk("nc_b3", nc_log[3], 8'h56);
    chk("nc_done", nc_done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
